// File: rtl/maze_char_controller_if.sv
// Signal bundle between the game logic and maze_char_controller.
// master drives buttons, maze description and control; slave returns position and status.
interface maze_char_controller_if;
   logic          enable;
   logic          load;
   logic          btn_up;
   logic          btn_down;
   logic          btn_left;
   logic          btn_right;
   logic [8191:0] path_data;
   logic [6:0]    maze_width;
   logic [6:0]    maze_height;
   logic [6:0]    start_x;
   logic [6:0]    start_y;
   logic [6:0]    goal_x;
   logic [6:0]    goal_y;
   logic [6:0]    char_x;
   logic [6:0]    char_y;
   logic          moved;
   logic          blocked;
   logic          at_goal;
   logic [15:0]   move_count;

   modport master (
      output enable, load, btn_up, btn_down, btn_left, btn_right, path_data,
             maze_width, maze_height, start_x, start_y, goal_x, goal_y,
      input  char_x, char_y, moved, blocked, at_goal, move_count
   );

   modport slave (
      input  enable, load, btn_up, btn_down, btn_left, btn_right, path_data,
             maze_width, maze_height, start_x, start_y, goal_x, goal_y,
      output char_x, char_y, moved, blocked, at_goal, move_count
   );
endinterface

// File: rtl/maze_char_controller.sv
// Debounced four-button character mover validated against the maze path bitmap.
// Optional hold-to-repeat requests are built only when CHAR_AUTO_REPEAT_EN is defined.
module maze_char_controller #(
   parameter int DEBOUNCE_CYCLES = 500_000,
   parameter int REPEAT_CYCLES   = 12_500_000
) (
   input logic                   clk,
   input logic                   reset,
   maze_char_controller_if.slave bus
);
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_CHECK, S_WON} state_t;

   state_t      state_q, state_d;
   logic [6:0]  x_q, x_d, y_q, y_d;
   logic [6:0]  tx_q, tx_d, ty_q, ty_d;
   logic        under_q, under_d;
   logic [15:0] cnt_q, cnt_d;
   logic        moved_q, moved_d, blocked_q, blocked_d, goal_q, goal_d;

   // Bit order everywhere: 0 = up, 1 = down, 2 = left, 3 = right.
   logic [3:0] btn_raw, deb_w, rise_w, flip_w, req_w;
   assign btn_raw = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
         logic [DB_W-1:0] db_cnt_q;
         logic            deb_q, rise_q;
         assign flip_w[gi] = (btn_raw[gi] != deb_q) && (db_cnt_q == DB_LAST);
         assign deb_w[gi]  = deb_q;
         assign rise_w[gi] = rise_q;
         always_ff @(posedge clk) begin
            if (!reset) begin
               db_cnt_q <= '0;
               deb_q    <= 1'b0;
               rise_q   <= 1'b0;
            end else begin
               rise_q <= 1'b0;
               if (btn_raw[gi] == deb_q) begin
                  db_cnt_q <= '0;
               end else if (db_cnt_q == DB_LAST) begin
                  db_cnt_q <= '0;
                  deb_q    <= btn_raw[gi];
                  rise_q   <= btn_raw[gi];
               end else begin
                  db_cnt_q <= db_cnt_q + 1'b1;
               end
            end
         end
      end
   endgenerate

`ifdef CHAR_AUTO_REPEAT_EN
   localparam int RP_W = $clog2(REPEAT_CYCLES + 1);
   localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_CYCLES - 1);
   logic [RP_W-1:0] rep_cnt_q;
   logic [3:0]      rep_q;

   // Counts only while a single button stays held with no debounced change.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rep_cnt_q <= '0;
         rep_q     <= '0;
      end else begin
         rep_q <= '0;
         if ((|flip_w) || !$onehot(deb_w)) begin
            rep_cnt_q <= '0;
         end else if (rep_cnt_q == RP_LAST) begin
            rep_cnt_q <= '0;
            rep_q     <= deb_w;
         end else begin
            rep_cnt_q <= rep_cnt_q + 1'b1;
         end
      end
   end
   assign req_w = rise_w | rep_q;
`else
   logic unused_repeat;
   assign unused_repeat = ^{flip_w, deb_w, REPEAT_CYCLES[0]};
   assign req_w = rise_w;
`endif

   logic [12:0] path_idx_w;
   logic        legal_w;
   assign path_idx_w = {ty_q, tx_q[5:0]};
   assign legal_w    = !under_q && (tx_q < bus.maze_width) && (ty_q < bus.maze_height)
                       && bus.path_data[path_idx_w];

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      tx_d      = tx_q;
      ty_d      = ty_q;
      under_d   = under_q;
      cnt_d     = cnt_q;
      moved_d   = 1'b0;
      blocked_d = 1'b0;
      goal_d    = goal_q;
      case (state_q)
         S_PLAY: begin
            if (bus.enable && (|req_w)) begin
               state_d = S_CHECK;
               tx_d    = x_q;
               ty_d    = y_q;
               under_d = 1'b0;
               if (req_w[0]) begin
                  under_d = (y_q == 7'd0);
                  ty_d    = y_q - 7'd1;
               end else if (req_w[1]) begin
                  ty_d = y_q + 7'd1;
               end else if (req_w[2]) begin
                  under_d = (x_q == 7'd0);
                  tx_d    = x_q - 7'd1;
               end else begin
                  tx_d = x_q + 7'd1;
               end
            end
         end
         S_CHECK: begin
            if (legal_w) begin
               x_d     = tx_q;
               y_d     = ty_q;
               moved_d = 1'b1;
               if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
               if (tx_q == bus.goal_x && ty_q == bus.goal_y) begin
                  state_d = S_WON;
                  goal_d  = 1'b1;
               end else begin
                  state_d = S_PLAY;
               end
            end else begin
               blocked_d = 1'b1;
               state_d   = S_PLAY;
            end
         end
         default: ;
      endcase
      // A new game overrides whatever the check stage decided this cycle.
      if (bus.load) begin
         state_d   = S_PLAY;
         x_d       = bus.start_x;
         y_d       = bus.start_y;
         cnt_d     = 16'd0;
         goal_d    = 1'b0;
         moved_d   = 1'b0;
         blocked_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         x_q       <= '0;
         y_q       <= '0;
         tx_q      <= '0;
         ty_q      <= '0;
         under_q   <= 1'b0;
         cnt_q     <= '0;
         moved_q   <= 1'b0;
         blocked_q <= 1'b0;
         goal_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         tx_q      <= tx_d;
         ty_q      <= ty_d;
         under_q   <= under_d;
         cnt_q     <= cnt_d;
         moved_q   <= moved_d;
         blocked_q <= blocked_d;
         goal_q    <= goal_d;
      end
   end

   assign bus.char_x     = x_q;
   assign bus.char_y     = y_q;
   assign bus.moved      = moved_q;
   assign bus.blocked    = blocked_q;
   assign bus.at_goal    = goal_q;
   assign bus.move_count = cnt_q;
endmodule

// File: tb/tb_maze_char_controller.sv
// Randomised scoreboard bench for maze_char_controller on a 4x4 maze.
// Expected move/blocked events come from a tile-level model and are matched by a monitor.
module tb_maze_char_controller;
   localparam int DB = 4;
   localparam int RP = 16;
   localparam int W  = 4;
   localparam int H  = 4;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   maze_char_controller_if bus();

   maze_char_controller #(.DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(RP)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   typedef struct {
      int kind;   // 1 = moved, 2 = blocked
      int x;
      int y;
      int cnt;
      int goal;
   } ev_t;

   ev_t exp_q[$];
   ev_t mon_e;
   int  n_checks = 0;
   int  n_fail   = 0;

   int mx = 0, my = 0, mcnt = 0, gx = 0, gy = 0;
   bit mplay = 0, mwon = 0, men = 1;
   logic [8191:0] maze;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Number of move requests a press of 'hold' raw cycles should produce.
   function automatic int n_requests(input int hold);
      if (hold < DB) return 0;
`ifdef CHAR_AUTO_REPEAT_EN
      return 1 + (hold - 1) / RP;
`else
      return 1;
`endif
   endfunction

   task automatic model_step(input int dir);
      int  tx, ty;
      ev_t e;
      if (!mplay || mwon || !men) return;
      tx = mx;
      ty = my;
      case (dir)
         0:       ty = ty - 1;
         1:       ty = ty + 1;
         2:       tx = tx - 1;
         default: tx = tx + 1;
      endcase
      if (tx >= 0 && ty >= 0 && tx < W && ty < H && maze[tx + 64 * ty]) begin
         mx = tx;
         my = ty;
         if (mcnt < 65535) mcnt++;
         if (mx == gx && my == gy) mwon = 1;
         e.kind = 1;
      end else begin
         e.kind = 2;
      end
      e.x    = mx;
      e.y    = my;
      e.cnt  = mcnt;
      e.goal = int'(mwon);
      exp_q.push_back(e);
   endtask

   task automatic set_btn(input int dir, input logic v);
      case (dir)
         0:       bus.btn_up    = v;
         1:       bus.btn_down  = v;
         2:       bus.btn_left  = v;
         default: bus.btn_right = v;
      endcase
   endtask

   task automatic check_state(input string tag);
      check({tag, "_queue_drained"}, exp_q.size(), 0);
      check({tag, "_char_x"}, int'(bus.char_x), mx);
      check({tag, "_char_y"}, int'(bus.char_y), my);
      check({tag, "_move_count"}, int'(bus.move_count), mcnt);
      check({tag, "_at_goal"}, int'(bus.at_goal), int'(mwon));
   endtask

   task automatic press(input int dir, input int hold, input bit chk_lat);
      for (int r = 0; r < n_requests(hold); r++) model_step(dir);
      @(posedge clk); #1;
      set_btn(dir, 1'b1);
      for (int i = 1; i <= hold; i++) begin
         @(posedge clk); #1;
         if (chk_lat && i == 5) check("latency_early", int'(bus.moved | bus.blocked), 0);
         if (chk_lat && i == 6) check("latency_pulse", int'(bus.moved | bus.blocked), 1);
      end
      set_btn(dir, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      check_state("press");
      $display("press dir=%0d hold=%0d en=%0d -> pos=(%0d,%0d) count=%0d goal=%0d",
               dir, hold, men, bus.char_x, bus.char_y, bus.move_count, bus.at_goal);
   endtask

   task automatic do_load(input int sx, input int sy, input int ggx, input int ggy);
      @(posedge clk); #1;
      bus.start_x   = 7'(sx);
      bus.start_y   = 7'(sy);
      bus.goal_x    = 7'(ggx);
      bus.goal_y    = 7'(ggy);
      bus.path_data = maze;
      bus.load      = 1'b1;
      @(posedge clk); #1;
      bus.load = 1'b0;
      mx = sx; my = sy; mcnt = 0; mwon = 0; mplay = 1; gx = ggx; gy = ggy;
      check_state("load");
      $display("load start=(%0d,%0d) goal=(%0d,%0d) -> pos=(%0d,%0d) count=%0d goal=%0d",
               sx, sy, ggx, ggy, bus.char_x, bus.char_y, bus.move_count, bus.at_goal);
   endtask

   // Scoreboard monitor: every moved/blocked pulse must match the next expected event.
   always @(negedge clk) begin
      if (reset && (bus.moved || bus.blocked)) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            check("ev_kind", int'({bus.blocked, bus.moved}), mon_e.kind);
            check("ev_char_x", int'(bus.char_x), mon_e.x);
            check("ev_char_y", int'(bus.char_y), mon_e.y);
            check("ev_move_count", int'(bus.move_count), mon_e.cnt);
            check("ev_at_goal", int'(bus.at_goal), mon_e.goal);
         end
      end
   end

   initial begin
      int op, hold;
      int holds [7] = '{2, 3, 6, 6, 6, 6, 44};

      bus.enable = 1'b1; bus.load = 1'b0;
      bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_left = 1'b0; bus.btn_right = 1'b0;
      bus.maze_width = 7'(W); bus.maze_height = 7'(H);
      bus.start_x = 7'd2; bus.start_y = 7'd3; bus.goal_x = 7'd3; bus.goal_y = 7'd3;
      maze = '0;
      bus.path_data = maze;

      // Reset held low, with load asserted during it: reset must win.
      repeat (2) @(posedge clk);
      #1 bus.load = 1'b1;
      @(posedge clk); #1;
      bus.load = 1'b0;
      check("rst_char_x", int'(bus.char_x), 0);
      check("rst_char_y", int'(bus.char_y), 0);
      check("rst_moved", int'(bus.moved), 0);
      check("rst_blocked", int'(bus.blocked), 0);
      check("rst_at_goal", int'(bus.at_goal), 0);
      check("rst_move_count", int'(bus.move_count), 0);
      reset = 1'b1;

      // Still IDLE: presses are dropped.
      press(1, 6, 1'b0);

      // Directed maze: (0,0), (1,1), (1,2) open; (2,1) closed; (4,0) open but outside width.
      maze[0] = 1'b1; maze[1 + 64] = 1'b1; maze[1 + 128] = 1'b1; maze[4] = 1'b1;
      do_load(1, 1, 3, 3);
      press(3, 6, 1'b0);        // blocked by closed tile
      press(3, 2, 1'b0);        // glitches
      press(3, 3, 1'b0);
      press(1, 6, 1'b1);        // legal move with latency check
      do_load(0, 0, 3, 3);
      press(2, 6, 1'b0);        // underflow x
      press(0, 6, 1'b0);        // underflow y
      press(3, 6, 1'b0);        // (1,0) closed
      do_load(1, 1, 1, 2);
      press(1, 6, 1'b0);        // onto goal
      press(0, 6, 1'b0);        // ignored in WON
      do_load(1, 1, 1, 2);
      men = 1'b0; bus.enable = 1'b0;
      press(1, 6, 1'b0);        // discarded while disabled
      men = 1'b1; bus.enable = 1'b1;

      // Open column x=0 and long hold.
      for (int y = 0; y < H; y++) maze[64 * y] = 1'b1;
      do_load(0, 0, 3, 3);
      press(1, 44, 1'b0);

      // Random phase.
      for (int it = 0; it < 70; it++) begin
         op = int'($urandom_range(0, 9));
         if (op == 0) begin
            for (int b = 0; b < 256; b++) maze[b] = 1'($urandom_range(0, 1));
            do_load(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         end else if (op == 1) begin
            men = ~men;
            bus.enable = men;
         end else begin
            hold = holds[$urandom_range(0, 6)];
            press(int'($urandom_range(0, 3)), hold, 1'b0);
         end
      end

      repeat (5) @(posedge clk);
      #1;
      check("final_queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/maze_char_controller.md
# maze_char_controller

Character movement controller sitting directly upstream of the maze renderer. It debounces four direction buttons and validates each requested step against the same `path_data` bitmap the renderer draws. It drives the `char_x`/`char_y` position the renderer consumes, and reports move pulses, blocked pulses, a move counter and goal detection to the game-level logic.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500_000: consecutive stable cycles required before a debounced button level changes.
- `REPEAT_CYCLES`, default 12_500_000: hold-repeat period in clocks; used only with `CHAR_AUTO_REPEAT_EN`.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-low reset; 0 = reset.
- `enable`  in  1  when 0, move requests are discarded; debouncers keep running.
- `load`  in  1  one-cycle pulse; starts a new game at (`start_x`, `start_y`).
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each  raw, active-high buttons.
- `path_data`  in  8192  open-tile bitmap; tile (x,y) is open when bit x + 64*y is 1.
- `maze_width`, `maze_height`  in  7 each  maze size in tiles.
- `start_x`, `start_y`, `goal_x`, `goal_y`  in  7 each  start and goal tile coordinates.
- `char_x`, `char_y`  out  7 each  current character tile.
- `moved`  out  1  one-cycle pulse when the position changes.
- `blocked`  out  1  one-cycle pulse when a request is rejected.
- `at_goal`  out  1  level; high while in WON.
- `move_count`  out  16  accepted moves since the last `load`.

## Operation
- Debounce, per button:
  - A counter runs while the raw input differs from the debounced level.
  - After `DEBOUNCE_CYCLES` consecutive differing cycles, the debounced level flips.
  - Any cycle where raw equals debounced clears the counter.
  - A debounced 0→1 edge raises a move request.
- Request arbitration:
  - A single request register holds one direction.
  - Priority on simultaneous edges: up > down > left > right.
  - A new request is accepted only in PLAY; requests arriving in other states are dropped, not queued.
- State machine:
  - IDLE: wait for `load`.
  - PLAY: latch the pending request if `enable`=1. Compute the target (tx, ty): up = y-1, down = y+1, left = x-1, right = x+1. Go to CHECK.
  - CHECK: the move is legal when all three hold:
    - no underflow below 0;
    - tx < `maze_width` and ty < `maze_height`;
    - `path_data`[tx + 64*ty] = 1.
  - CHECK, legal: update `char_x`/`char_y`, pulse `moved`, increment `move_count` (saturates at 16'hFFFF). Go to WON if the target equals (`goal_x`, `goal_y`), else go to PLAY.
  - CHECK, illegal: pulse `blocked`, position unchanged, return to PLAY.
  - WON: `at_goal`=1; all buttons ignored until `load`.
- `load` from any state:
  - `char_x`/`char_y` ← start, `move_count` ← 0, `at_goal` ← 0, go to PLAY.
  - Start coordinates are not validated.
  - If start equals goal, the block stays in PLAY; the goal is detected only on a move.
- Index arithmetic is 13-bit, computed as {ty[6:0], tx[5:0]}. `maze_width` > 64 is out of spec.

## Timing
- Reset values: `char_x`=0, `char_y`=0, `moved`=0, `blocked`=0, `at_goal`=0, `move_count`=0. State = IDLE; debounced levels, counters and the request register are all 0.
- `reset`=0 overrides `load` in the same cycle.
- Latency:
  - Debounced edge in cycle N → request latched at the N+1 edge → CHECK → position, `moved`/`blocked` and `move_count` update at the N+2 edge.
  - Outputs are registered; `moved` and `blocked` are high for exactly one cycle.
- `load` in the same cycle as a CHECK result: `load` wins, the move is discarded and no pulse is issued.
- `enable` falling while in CHECK: the in-flight move completes.
- Minimum spacing between accepted moves: 2 cycles.

## Configuration
- `CHAR_AUTO_REPEAT_EN` defined:
  - While exactly one debounced button stays high, a repeat counter issues a new request every `REPEAT_CYCLES` cycles after the initial edge.
  - The counter resets on release or on any button change.
- `CHAR_AUTO_REPEAT_EN` undefined: only 0→1 edges generate requests; the repeat counter is not synthesized.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `REPEAT_CYCLES`=16 and a 4×4 maze.
- Reset, then `load` with start (1,1) → `char_x`=1, `char_y`=1, `move_count`=0, `at_goal`=0.
- (1,2) open, `btn_down` held 6 cycles → `char_y`=2 exactly 2 cycles after the debounce edge; `moved` one pulse; `move_count`=1.
- At (0,0), press `btn_left`; then press `btn_up` → two `blocked` pulses, position stays (0,0), `move_count`=0.
- Target (2,1) is closed, press `btn_right` → `blocked`=1 one cycle; 2-pulse glitches shorter than 4 cycles → no request at all.
- Goal (1,2), move onto it → `at_goal`=1 at the same edge as `moved`; further presses → no change; `load` → `at_goal`=0.
- `CHAR_AUTO_REPEAT_EN` defined, open column, `btn_down` held 40 cycles after debounce → 3 moves; with the macro undefined → 1 move.
